// File: rtl/btn_debounce_fsm_pkg.sv
// State encoding and default timer width for the button debouncer.
package btn_debounce_fsm_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam int N_DEFAULT = 20;

endpackage

// File: rtl/btn_debounce_fsm_if.sv
// Raw button input and its debounced level/tick; master drives sw, slave is the debouncer.
interface btn_debounce_fsm_if;
    logic sw;
    logic db_level;
    logic db_tick;

    modport master (output sw, input db_level, input db_tick);
    modport slave  (input sw, output db_level, output db_tick);
endinterface

// File: rtl/btn_debounce_fsm_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; 2-cycle latency, no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/btn_debounce_fsm.sv
// Button debouncer: level changes after sw holds steady for 2^N clocks, tick in the cycle before the rise.
// No backpressure. BTN_DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser (+2 cycles latency).
module btn_debounce_fsm
    import btn_debounce_fsm_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    btn_debounce_fsm_if.slave  bus
);
    localparam logic [N-1:0] Q_MAX = '1;

    state_t       state;
    logic [N-1:0] q;
    logic         sw_s;

`ifdef BTN_DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sw),
        .q     (sw_s)
    );
`else
    assign sw_s = bus.sw;
`endif

    // Any opposite sample in a WAIT state falls back to the stable state, so partial intervals never add up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
            q     <= '0;
        end else begin
            case (state)
                ZERO: begin
                    if (sw_s) begin
                        state <= WAIT1;
                        q     <= Q_MAX;
                    end
                end
                WAIT1: begin
                    if (!sw_s)         state <= ZERO;
                    else if (q != '0)  q     <= q - 1'b1;
                    else               state <= ONE;
                end
                ONE: begin
                    if (!sw_s) begin
                        state <= WAIT0;
                        q     <= Q_MAX;
                    end
                end
                WAIT0: begin
                    if (sw_s)          state <= ONE;
                    else if (q != '0)  q     <= q - 1'b1;
                    else               state <= ZERO;
                end
                default: state <= ZERO;
            endcase
        end
    end

    assign bus.db_level = (state == ONE) || (state == WAIT0);
    assign bus.db_tick  = (state == WAIT1) && sw_s && (q == '0);

endmodule
